// File: rtl/spi_slave_responder_if.sv
// Byte-wide SPI responder bus: raw SPI pins plus the fabric-side tx/rx handshake.
// The master modport is the SPI master and fabric side; the slave modport is the responder.
interface spi_slave_responder_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_bar;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_error;

    modport master (
        output sclk, cs_bar, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_error
    );

    modport slave (
        input  sclk, cs_bar, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_error
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder oversampled on clk; rx_valid SYNC_STAGES+2 clk after the last sclk rise.
// One-entry tx buffer: tx_load is ignored while tx_ready=0, and a frame consumes it or underruns.
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = '0
) (
    input logic                  clk,
    input logic                  reset,
    spi_slave_responder_if.slave bus
);
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] rx_shift_q, rx_data_q, tx_shift_q, tx_buf_q;
    logic              tx_ready_q, miso_q, rx_done_q, rx_valid_q;
    logic              tx_underrun_q, frame_error_q;
    logic              byte_done_q, commit_pend_q, pend_full_q;
    logic [DATA_W-1:0] next_tx_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign next_tx_d = tx_ready_q ? IDLE_BYTE : tx_buf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_bar};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            miso_q        <= 1'b0;
            rx_done_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= 1'b0;
            byte_done_q   <= 1'b0;
            commit_pend_q <= 1'b0;
            pend_full_q   <= 1'b0;
        end else begin
            rx_valid_q    <= rx_done_q;
            rx_done_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= 1'b0;

            if (bus.tx_load && tx_ready_q) begin
                tx_buf_q   <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q       <= ACTIVE;
                        bit_cnt_q     <= '0;
                        byte_done_q   <= 1'b0;
                        commit_pend_q <= 1'b0;
                        tx_shift_q    <= next_tx_d;
                        miso_q        <= next_tx_d[DATA_W-1];
                        if (tx_ready_q) tx_underrun_q <= 1'b1;
                        else            tx_ready_q    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q       <= IDLE;
                        miso_q        <= 1'b0;
                        bit_cnt_q     <= '0;
                        commit_pend_q <= 1'b0;
                        byte_done_q   <= 1'b0;
                        if (bit_cnt_q != '0) frame_error_q <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                        // A back-to-back reload is only committed once the next byte really starts,
                        // so the trailing sclk fall of a frame never consumes or underruns.
                        if (commit_pend_q) begin
                            commit_pend_q <= 1'b0;
                            if (pend_full_q) tx_ready_q    <= 1'b1;
                            else             tx_underrun_q <= 1'b1;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q   <= {rx_shift_q[DATA_W-2:0], mosi_s};
                            rx_done_q   <= 1'b1;
                            bit_cnt_q   <= '0;
                            byte_done_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q != '0) begin
                            tx_shift_q <= tx_shift_q << 1;
                            miso_q     <= tx_shift_q[DATA_W-2];
                        end else if (byte_done_q) begin
                            byte_done_q   <= 1'b0;
                            commit_pend_q <= 1'b1;
                            pend_full_q   <= ~tx_ready_q;
                            tx_shift_q    <= next_tx_d;
                            miso_q        <= next_tx_d[DATA_W-1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.miso        = miso_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-banged SPI master at clk/10 plus a byte-level model
// of what the responder should return, receive and flag.
module tb_spi_slave_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rx_cnt = 0, und_cnt = 0, ferr_cnt = 0;
    logic [7:0] rx_q[$];

    spi_slave_responder_if #(.DATA_W(8)) bus();

    spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            rx_cnt++;
            rx_q.push_back(bus.rx_data);
        end
        if (bus.tx_underrun === 1'b1) und_cnt++;
        if (bus.frame_error === 1'b1) ferr_cnt++;
    end

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.cs_bar = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (6) @(negedge clk);
        bus.cs_bar = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Shifts nbits of mo MSB-first; optionally loads load_val right after rise number load_bit.
    task automatic xfer(input logic [7:0] mo, input int nbits, input int load_bit,
                        input logic [7:0] load_val, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            repeat (5) @(negedge clk);
            bus.sclk = 1'b1;
            mi[7-i] = bus.miso;
            if (i == load_bit) begin
                bus.tx_data = load_val;
                bus.tx_load = 1'b1;
                @(negedge clk);
                bus.tx_load = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        logic [7:0] got;
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no received byte, expected %h", name, exp);
        end else begin
            got = rx_q.pop_front();
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s: rx byte %h, expected %h", name, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        bus.sclk = 1'b0; bus.cs_bar = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_load = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: %b vs 0", bus.miso); end
        vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: %b vs 1", bus.tx_ready); end
        vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: %b vs 0", bus.rx_valid); end
        vectors++; if (bus.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: %h vs 00", bus.rx_data); end
        vectors++; if (bus.tx_underrun !== 1'b0 || bus.frame_error !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses: und=%b ferr=%b vs 0 0", bus.tx_underrun, bus.frame_error); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        int r0 = rx_cnt, u0 = und_cnt;
        load_byte(8'hA5);
        vectors++; if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL basic_loaded_ready: %b vs 0", bus.tx_ready); end
        load_byte(8'h11);  // ignored: buffer already full
        cs_low();
        vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_after_cs: %b vs 1", bus.tx_ready); end
        xfer(8'h3C, 8, -1, 8'h00, mi);
        cs_high();
        vectors++; if (mi !== 8'hA5) begin miscompares++; $display("FAIL basic_miso: %h vs a5", mi); end
        vectors++; if (rx_cnt - r0 !== 1) begin miscompares++; $display("FAIL basic_rx_pulses: %0d vs 1", rx_cnt - r0); end
        vectors++; if (bus.rx_data !== 8'h3C) begin miscompares++; $display("FAIL basic_rx_data: %h vs 3c", bus.rx_data); end
        vectors++; if (und_cnt - u0 !== 0) begin miscompares++; $display("FAIL basic_underrun: %0d vs 0", und_cnt - u0); end
        check_rx("basic_rx_q", 8'h3C);
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi0, mi1;
        int r0 = rx_cnt, u0 = und_cnt;
        load_byte(8'h81);
        cs_low();
        xfer(8'h12, 8, 3, 8'h7E, mi0);
        xfer(8'h34, 8, -1, 8'h00, mi1);
        cs_high();
        vectors++; if (mi0 !== 8'h81) begin miscompares++; $display("FAIL b2b_miso0: %h vs 81", mi0); end
        vectors++; if (mi1 !== 8'h7E) begin miscompares++; $display("FAIL b2b_miso1: %h vs 7e", mi1); end
        vectors++; if (rx_cnt - r0 !== 2) begin miscompares++; $display("FAIL b2b_rx_pulses: %0d vs 2", rx_cnt - r0); end
        vectors++; if (und_cnt - u0 !== 0) begin miscompares++; $display("FAIL b2b_underrun: %0d vs 0", und_cnt - u0); end
        check_rx("b2b_rx0", 8'h12);
        check_rx("b2b_rx1", 8'h34);
    endtask

    task automatic test_underrun();
        logic [7:0] mi, mo;
        int r0 = rx_cnt, u0 = und_cnt;
        mo = 8'($urandom_range(1, 255));
        cs_low();
        xfer(mo, 8, -1, 8'h00, mi);
        cs_high();
        vectors++; if (und_cnt - u0 !== 1) begin miscompares++; $display("FAIL und_pulses: %0d vs 1", und_cnt - u0); end
        vectors++; if (mi !== 8'h00) begin miscompares++; $display("FAIL und_miso: %h vs 00", mi); end
        vectors++; if (rx_cnt - r0 !== 1) begin miscompares++; $display("FAIL und_rx_pulses: %0d vs 1", rx_cnt - r0); end
        check_rx("und_rx", mo);
    endtask

    task automatic test_frame_error();
        logic [7:0] mi;
        int r0 = rx_cnt, f0 = ferr_cnt;
        load_byte(8'($urandom));
        cs_low();
        xfer(8'($urandom), 5, -1, 8'h00, mi);
        cs_high();
        vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_pulses: %0d vs 1", ferr_cnt - f0); end
        vectors++; if (rx_cnt - r0 !== 0) begin miscompares++; $display("FAIL ferr_rx_pulses: %0d vs 0", rx_cnt - r0); end
        cs_low();
        xfer(8'hC3, 8, -1, 8'h00, mi);
        cs_high();
        vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_after_full: %0d vs 1", ferr_cnt - f0); end
        check_rx("ferr_next_rx", 8'hC3);
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, v;
        int r0 = rx_cnt, f0 = ferr_cnt;
        load_byte(8'($urandom));
        cs_low();
        xfer(8'($urandom), 4, -1, 8'h00, mi);
        reset = 1'b0;
        bus.cs_bar = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        vectors++; if (bus.miso !== 1'b0) begin miscompares++; $display("FAIL rmid_miso: %b vs 0", bus.miso); end
        vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_tx_ready: %b vs 1", bus.tx_ready); end
        vectors++; if (bus.rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_rx_data: %h vs 00", bus.rx_data); end
        vectors++; if (rx_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin
            miscompares++; $display("FAIL rmid_pulses: rx=%0d ferr=%0d vs 0 0", rx_cnt - r0, ferr_cnt - f0); end
        v = 8'($urandom);
        load_byte(v);
        cs_low();
        xfer(8'h5A, 8, -1, 8'h00, mi);
        cs_high();
        vectors++; if (mi !== v) begin miscompares++; $display("FAIL rmid_next_miso: %h vs %h", mi, v); end
        check_rx("rmid_next_rx", 8'h5A);
    endtask

    // Random frames of 1-3 bytes; each byte is either preloaded or left to underrun.
    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int nb = $urandom_range(1, 3);
            int u0 = und_cnt, r0 = rx_cnt, exp_und = 0;
            logic       ld[3];
            logic [7:0] val[3], mo[3], mi;
            for (int k = 0; k < 3; k++) begin
                ld[k] = 1'($urandom);
                val[k] = 8'($urandom);
                mo[k] = 8'($urandom);
                if (k < nb && !ld[k]) exp_und++;
            end
            if (ld[0]) load_byte(val[0]);
            cs_low();
            for (int k = 0; k < nb; k++) begin
                int lb = (k + 1 < nb && ld[k+1]) ? int'($urandom_range(1, 6)) : -1;
                xfer(mo[k], 8, lb, (k + 1 < 3) ? val[k+1] : 8'h00, mi);
                vectors++;
                if (mi !== (ld[k] ? val[k] : 8'h00)) begin
                    miscompares++;
                    $display("FAIL rand_miso f%0d b%0d: %h vs %h", f, k, mi, ld[k] ? val[k] : 8'h00);
                end
            end
            cs_high();
            vectors++; if (und_cnt - u0 !== exp_und) begin miscompares++; $display("FAIL rand_underrun f%0d: %0d vs %0d", f, und_cnt - u0, exp_und); end
            vectors++; if (rx_cnt - r0 !== nb) begin miscompares++; $display("FAIL rand_rx_pulses f%0d: %0d vs %0d", f, rx_cnt - r0, nb); end
            for (int k = 0; k < nb; k++) check_rx("rand_rx", mo[k]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_frame_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
